// File: rtl/lc3_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the LC3 memory arbiter.
// The master modport is the arbiter; the slave modport is whatever surrounds it.
interface lc3_mem_arbiter_if;
    logic        instr_req;
    logic [15:0] pc;
    logic [15:0] instr_dout;
    logic        complete_instr;

    logic        data_req;
    logic        data_wr;
    logic        data_ind;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout;
    logic        complete_data;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    logic [1:0]  mem_state;
    logic        timeout_err;

    modport master (
        input  instr_req, pc, data_req, data_wr, data_ind, data_addr, data_din,
        input  mem_rdata, mem_ack,
        output instr_dout, complete_instr, data_dout, complete_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_state, timeout_err
    );

    modport slave (
        output instr_req, pc, data_req, data_wr, data_ind, data_addr, data_din,
        output mem_rdata, mem_ack,
        input  instr_dout, complete_instr, data_dout, complete_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_state, timeout_err
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Shares one memory port between LC3 instruction fetch and data access, sequencing
// indirect accesses, bounding starvation with a fairness count and stalls with a watchdog.
module lc3_mem_arbiter #(
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic               clock,
    input  logic               reset,
    lc3_mem_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        I_ACC,
        D_PTR,
        D_ARM,
        D_RD,
        D_WR,
        DONE
    } state_e;

    localparam logic [3:0] FAIR_L    = 4'(FAIR_LIMIT);
    localparam logic [7:0] WAIT_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit         WD_ON     = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic        memEn_q, memEn_d;
    logic        ownerData_q, ownerData_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] instrDout_q, instrDout_d;
    logic [15:0] dataDout_q, dataDout_d;
    logic        completeInstr_q, completeInstr_d;
    logic        completeData_q, completeData_d;
    logic        timeoutErr_q, timeoutErr_d;
    logic [3:0]  fairCnt_q, fairCnt_d;
    logic [7:0]  waitCnt_q, waitCnt_d;

    logic ackSeen;
    logic timeoutHit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            memEn_q         <= 1'b0;
            ownerData_q     <= 1'b0;
            wr_q            <= 1'b0;
            addr_q          <= 16'h0000;
            din_q           <= 16'h0000;
            ptr_q           <= 16'h0000;
            instrDout_q     <= 16'h0000;
            dataDout_q      <= 16'h0000;
            completeInstr_q <= 1'b0;
            completeData_q  <= 1'b0;
            timeoutErr_q    <= 1'b0;
            fairCnt_q       <= 4'd0;
            waitCnt_q       <= 8'd0;
        end else begin
            state_q         <= state_d;
            memEn_q         <= memEn_d;
            ownerData_q     <= ownerData_d;
            wr_q            <= wr_d;
            addr_q          <= addr_d;
            din_q           <= din_d;
            ptr_q           <= ptr_d;
            instrDout_q     <= instrDout_d;
            dataDout_q      <= dataDout_d;
            completeInstr_q <= completeInstr_d;
            completeData_q  <= completeData_d;
            timeoutErr_q    <= timeoutErr_d;
            fairCnt_q       <= fairCnt_d;
            waitCnt_q       <= waitCnt_d;
        end
    end

    // An ack on the same edge as the watchdog limit wins, so timeoutHit excludes ack.
    always_comb begin
        state_d         = state_q;
        memEn_d         = memEn_q;
        ownerData_d     = ownerData_q;
        wr_d            = wr_q;
        addr_d          = addr_q;
        din_d           = din_q;
        ptr_d           = ptr_q;
        instrDout_d     = instrDout_q;
        dataDout_d      = dataDout_q;
        completeInstr_d = 1'b0;
        completeData_d  = 1'b0;
        timeoutErr_d    = 1'b0;
        fairCnt_d       = fairCnt_q;

        ackSeen    = memEn_q && bus.mem_ack;
        timeoutHit = WD_ON && memEn_q && !bus.mem_ack && (waitCnt_q == WAIT_LAST);
        waitCnt_d  = (memEn_q && !bus.mem_ack) ? 8'(waitCnt_q + 8'd1) : 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.data_req && !(bus.instr_req && fairCnt_q == FAIR_L)) begin
                    ownerData_d = 1'b1;
                    wr_d        = bus.data_wr;
                    addr_d      = bus.data_addr;
                    din_d       = bus.data_din;
                    memEn_d     = 1'b1;
                    if (bus.data_ind)
                        state_d = D_PTR;
                    else if (bus.data_wr)
                        state_d = D_WR;
                    else
                        state_d = D_RD;
                    if (bus.instr_req)
                        fairCnt_d = (fairCnt_q == FAIR_L) ? fairCnt_q : 4'(fairCnt_q + 4'd1);
                    else
                        fairCnt_d = 4'd0;
                end else if (bus.instr_req) begin
                    ownerData_d = 1'b0;
                    wr_d        = 1'b0;
                    addr_d      = bus.pc;
                    memEn_d     = 1'b1;
                    fairCnt_d   = 4'd0;
                    state_d     = I_ACC;
                end
            end
            I_ACC: begin
                if (ackSeen) begin
                    instrDout_d = bus.mem_rdata;
                    memEn_d     = 1'b0;
                    state_d     = DONE;
                end else if (timeoutHit) begin
                    instrDout_d  = 16'hFFFF;
                    memEn_d      = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = DONE;
                end
            end
            D_PTR: begin
                if (ackSeen) begin
                    ptr_d   = bus.mem_rdata;
                    memEn_d = 1'b0;
                    state_d = D_ARM;
                end else if (timeoutHit) begin
                    if (!wr_q)
                        dataDout_d = 16'hFFFF;
                    memEn_d      = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = DONE;
                end
            end
            D_ARM: begin
                addr_d  = ptr_q;
                memEn_d = 1'b1;
                state_d = wr_q ? D_WR : D_RD;
            end
            D_RD: begin
                if (ackSeen) begin
                    dataDout_d = bus.mem_rdata;
                    memEn_d    = 1'b0;
                    state_d    = DONE;
                end else if (timeoutHit) begin
                    dataDout_d   = 16'hFFFF;
                    memEn_d      = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = DONE;
                end
            end
            D_WR: begin
                if (ackSeen) begin
                    memEn_d = 1'b0;
                    state_d = DONE;
                end else if (timeoutHit) begin
                    memEn_d      = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                memEn_d = 1'b0;
            end
        endcase

        if (state_d == DONE && state_q != DONE) begin
            completeInstr_d = !ownerData_q;
            completeData_d  = ownerData_q;
        end
    end

    always_comb begin
        case (state_q)
            D_PTR, D_ARM: bus.mem_state = 2'd1;
            D_RD:         bus.mem_state = 2'd0;
            D_WR:         bus.mem_state = 2'd2;
            default:      bus.mem_state = 2'd3;
        endcase
    end

    assign bus.mem_en         = memEn_q;
    assign bus.mem_we         = memEn_q && (state_q == D_WR);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = din_q;
    assign bus.instr_dout     = instrDout_q;
    assign bus.data_dout      = dataDout_q;
    assign bus.complete_instr = completeInstr_q;
    assign bus.complete_data  = completeData_q;
    assign bus.timeout_err    = timeoutErr_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a zero-wait memory model that acks whenever
// mem_en is high (unless ack is withheld) and returns fixed words per address.
module tb_lc3_mem_arbiter;

    logic clock;
    logic reset;
    logic ackEnable;

    int compareCount;
    int mismatchCount;

    lc3_mem_arbiter_if bus ();

    lc3_mem_arbiter #(
        .FAIR_LIMIT (4),
        .TIMEOUT    (15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    function automatic logic [15:0] readData(input logic [15:0] addr);
        case (addr)
            16'h3000: return 16'h1234;
            16'h4000: return 16'h5005;
            default:  return 16'hC0DE;
        endcase
    endfunction

    assign bus.mem_ack   = bus.mem_en & ackEnable;
    assign bus.mem_rdata = readData(bus.mem_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [15:0] pcVal,
                                 input logic dReq, input logic wr, input logic ind,
                                 input logic [15:0] addr, input logic [15:0] din);
        bus.instr_req = iReq;
        bus.pc        = pcVal;
        bus.data_req  = dReq;
        bus.data_wr   = wr;
        bus.data_ind  = ind;
        bus.data_addr = addr;
        bus.data_din  = din;
    endtask

    initial begin
        logic expOwner [10];
        logic gotOwner [10];
        int   nDone;
        int   highCount;

        compareCount  = 0;
        mismatchCount = 0;
        ackEnable     = 1'b1;
        expOwner      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'h0);
        checkOutput("rst_mem_state", 32'(bus.mem_state), 32'h3);
        checkOutput("rst_complete", 32'({bus.complete_instr, bus.complete_data, bus.timeout_err}), 32'h0);
        checkOutput("rst_douts", 32'({bus.instr_dout, bus.data_dout}), 32'h0);
        #2 reset = 1'b0;
        tick();

        // plain fetch
        applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        checkOutput("t1_grant_en", 32'(bus.mem_en), 32'h1);
        checkOutput("t1_addr", 32'(bus.mem_addr), 32'h3000);
        checkOutput("t1_we", 32'(bus.mem_we), 32'h0);
        checkOutput("t1_state", 32'(bus.mem_state), 32'h3);
        checkOutput("t1_no_early_cpl", 32'(bus.complete_instr), 32'h0);
        tick();
        checkOutput("t1_cpl", 32'(bus.complete_instr), 32'h1);
        checkOutput("t1_en_low", 32'(bus.mem_en), 32'h0);
        checkOutput("t1_dout", 32'(bus.instr_dout), 32'h1234);
        bus.instr_req = 1'b0;
        tick();
        checkOutput("t1_cpl_pulse", 32'(bus.complete_instr), 32'h0);

        // simultaneous requests: data first, fetch after the idle cycle
        applyStimulus(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000);
        tick();
        checkOutput("t2_data_first_state", 32'(bus.mem_state), 32'h0);
        checkOutput("t2_data_addr", 32'(bus.mem_addr), 32'h4000);
        tick();
        checkOutput("t2_cpl_data", 32'({bus.complete_data, bus.complete_instr}), 32'h2);
        checkOutput("t2_data_dout", 32'(bus.data_dout), 32'h5005);
        bus.data_req = 1'b0;
        tick();
        checkOutput("t2_idle_gap", 32'(bus.mem_en), 32'h0);
        tick();
        checkOutput("t2_fetch_grant", 32'({bus.mem_en, bus.mem_addr}), 32'h13000);
        tick();
        checkOutput("t2_fetch_cpl", 32'(bus.complete_instr), 32'h1);
        bus.instr_req = 1'b0;
        tick();

        // indirect store with inputs changed after grant
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h4000, 16'hBEEF);
        tick();
        checkOutput("t3_ptr_en", 32'({bus.mem_en, bus.mem_we}), 32'h2);
        checkOutput("t3_ptr_addr", 32'(bus.mem_addr), 32'h4000);
        checkOutput("t3_state_a", 32'(bus.mem_state), 32'h1);
        bus.data_addr = 16'h0000;
        bus.data_din  = 16'h0000;
        tick();
        checkOutput("t3_gap_en", 32'(bus.mem_en), 32'h0);
        checkOutput("t3_state_b", 32'(bus.mem_state), 32'h1);
        tick();
        checkOutput("t3_wr_en_we", 32'({bus.mem_en, bus.mem_we}), 32'h3);
        checkOutput("t3_wr_addr", 32'(bus.mem_addr), 32'h5005);
        checkOutput("t3_wr_data", 32'(bus.mem_wdata), 32'hBEEF);
        checkOutput("t3_state_c", 32'(bus.mem_state), 32'h2);
        tick();
        checkOutput("t3_cpl", 32'(bus.complete_data), 32'h1);
        checkOutput("t3_state_d", 32'(bus.mem_state), 32'h3);
        checkOutput("t3_dout_kept", 32'(bus.data_dout), 32'h5005);
        bus.data_req = 1'b0;
        tick();

        // fairness with both requests held
        applyStimulus(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000);
        nDone = 0;
        for (int c = 0; c < 60 && nDone < 10; c++) begin
            tick();
            if (bus.complete_data) begin
                gotOwner[nDone] = 1'b1;
                nDone++;
            end else if (bus.complete_instr) begin
                gotOwner[nDone] = 1'b0;
                nDone++;
            end
        end
        checkOutput("t4_grant_count", 32'(nDone), 32'd10);
        for (int k = 0; k < nDone; k++)
            checkOutput($sformatf("t4_grant_%0d", k), 32'(gotOwner[k]), 32'(expOwner[k]));
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        tick();
        tick();

        // watchdog on a load that is never acked
        ackEnable = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000);
        tick();
        highCount = bus.mem_en ? 1 : 0;
        for (int c = 0; c < 40 && bus.mem_en; c++) begin
            tick();
            if (bus.mem_en)
                highCount++;
        end
        checkOutput("t5_high_cycles", 32'(highCount), 32'd15);
        checkOutput("t5_cpl_err", 32'({bus.complete_data, bus.timeout_err}), 32'h3);
        checkOutput("t5_dout", 32'(bus.data_dout), 32'hFFFF);
        bus.data_req = 1'b0;
        ackEnable    = 1'b1;
        tick();
        checkOutput("t5_err_pulse", 32'(bus.timeout_err), 32'h0);
        tick();

        // asynchronous reset in the middle of a write
        ackEnable = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h6000, 16'h1111);
        tick();
        checkOutput("t6_in_write", 32'({bus.mem_en, bus.mem_we, bus.mem_state}), 32'hE);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_async_drop", 32'({bus.mem_en, bus.mem_we, bus.mem_state}), 32'h3);
        checkOutput("t6_dout_clr", 32'(bus.data_dout), 32'h0);
        bus.data_req = 1'b0;
        ackEnable    = 1'b1;
        tick();
        checkOutput("t6_no_cpl_a", 32'(bus.complete_data), 32'h0);
        #2 reset = 1'b0;
        tick();
        checkOutput("t6_no_cpl_b", 32'(bus.complete_data), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000);
        tick();
        checkOutput("t6_regrant", 32'({bus.mem_en, bus.mem_state}), 32'h4);
        tick();
        checkOutput("t6_after_cpl", 32'({bus.complete_data, bus.data_dout}), 32'h11234);
        bus.data_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
